// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - word write port and byte stream bundle for uart_tx_framer
interface uart_tx_framer_if #(
    parameter int REG_SIZE = 32,
    parameter int DEPTH    = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [REG_SIZE-1:0] tx_reg;
    logic                tx_en;
    logic                tx_full;
    logic [LW-1:0]       tx_level;
    logic                tx_overflow;
    logic                tx_busy;
    logic [7:0]          tx_data;
    logic                tx_data_valid;
    logic                tx_data_ready;
    logic                tx_frame_done;

    modport master (
        output tx_reg, tx_en, tx_data_ready,
        input  tx_full, tx_level, tx_overflow, tx_busy,
        input  tx_data, tx_data_valid, tx_frame_done
    );

    modport slave (
        input  tx_reg, tx_en, tx_data_ready,
        output tx_full, tx_level, tx_overflow, tx_busy,
        output tx_data, tx_data_valid, tx_frame_done
    );
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - word FIFO plus MSB-first byte serialiser with inter-frame idle gap
module uart_tx_framer #(
    parameter int REG_SIZE   = 32,
    parameter int DEPTH      = 4,
    parameter int IDLE_CYCLE = 20
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_framer_if.slave  bus
);
    localparam int NBYTES = REG_SIZE / 8;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GW     = (IDLE_CYCLE > 1) ? $clog2(IDLE_CYCLE) : 1;

    localparam logic [BW-1:0] LAST_BYTE  = BW'(NBYTES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((IDLE_CYCLE > 0) ? IDLE_CYCLE - 1 : 0);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [REG_SIZE-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [REG_SIZE-1:0] shift;
    logic [BW-1:0]       byte_cnt;
    logic [GW-1:0]       gap_cnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                handshake;
    logic                last_byte;

    // Fullness uses the pre-edge level, so a pop in the same cycle never admits a write.
    assign fifo_full  = (level == FULL_LEVEL);
    assign fifo_empty = (level == '0);
    assign push       = bus.tx_en && !fifo_full;
    assign handshake  = (state == SEND) && bus.tx_data_ready;
    assign last_byte  = (byte_cnt == LAST_BYTE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (handshake && last_byte) begin
                    if (IDLE_CYCLE > 0) state_nxt = GAP;
                    else                state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Storage is not reset; the pointers and level alone define what is queued.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.tx_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= fifo_mem[rd_ptr];
                        byte_cnt <= '0;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (last_byte) begin
                            gap_cnt <= '0;
                        end else begin
                            shift    <= shift << 8;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                GAP:     gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.tx_full       = fifo_full;
    assign bus.tx_level      = level;
    assign bus.tx_overflow   = bus.tx_en && fifo_full;
    assign bus.tx_busy       = (state != IDLE) || !fifo_empty;
    assign bus.tx_data       = shift[REG_SIZE-1 -: 8];
    assign bus.tx_data_valid = (state == SEND);
    assign bus.tx_frame_done = handshake && last_byte;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer
module tb_uart_tx_framer;
    localparam int RS = 32;
    localparam int DP = 4;
    localparam int LW = $clog2(DP) + 1;
    localparam int QN = 256;

    typedef struct {
        logic          en;
        logic [31:0]   word;
        logic [LW-1:0] level;
        logic          full;
        logic          ovf;
        logic          valid;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_d   [2];
    logic          en_d    [2];
    logic [31:0]   reg_d   [2];
    logic          rdy_d   [2];
    logic [7:0]    data_s  [2];
    logic          valid_s [2];
    logic          done_s  [2];
    logic          busy_s  [2];
    logic          full_s  [2];
    logic          ovf_s   [2];
    logic [LW-1:0] lvl_s   [2];

    uart_tx_framer_if #(.REG_SIZE(RS), .DEPTH(DP)) bus_a ();
    uart_tx_framer_if #(.REG_SIZE(RS), .DEPTH(DP)) bus_b ();

    uart_tx_framer #(.REG_SIZE(RS), .DEPTH(DP), .IDLE_CYCLE(20)) dut_a (
        .clk (clk),
        .rst (rst_d[0]),
        .bus (bus_a.slave)
    );

    uart_tx_framer #(.REG_SIZE(RS), .DEPTH(DP), .IDLE_CYCLE(0)) dut_b (
        .clk (clk),
        .rst (rst_d[1]),
        .bus (bus_b.slave)
    );

    assign bus_a.tx_en         = en_d[0];
    assign bus_a.tx_reg        = reg_d[0];
    assign bus_a.tx_data_ready = rdy_d[0];
    assign bus_b.tx_en         = en_d[1];
    assign bus_b.tx_reg        = reg_d[1];
    assign bus_b.tx_data_ready = rdy_d[1];

    assign data_s[0]  = bus_a.tx_data;
    assign valid_s[0] = bus_a.tx_data_valid;
    assign done_s[0]  = bus_a.tx_frame_done;
    assign busy_s[0]  = bus_a.tx_busy;
    assign full_s[0]  = bus_a.tx_full;
    assign ovf_s[0]   = bus_a.tx_overflow;
    assign lvl_s[0]   = bus_a.tx_level;
    assign data_s[1]  = bus_b.tx_data;
    assign valid_s[1] = bus_b.tx_data_valid;
    assign done_s[1]  = bus_b.tx_frame_done;
    assign busy_s[1]  = bus_b.tx_busy;
    assign full_s[1]  = bus_b.tx_full;
    assign ovf_s[1]   = bus_b.tx_overflow;
    assign lvl_s[1]   = bus_b.tx_level;

    // Reference model: expected byte stream per instance as a ring of bytes.
    logic [7:0]  exp_mem [2][QN];
    int          exp_wr     [2];
    int          exp_rd     [2];
    int          low_run    [2];
    bit          gap_armed  [2];
    bit          prev_stall [2];
    logic [7:0]  prev_data  [2];
    bit          mon_hs;
    bit          mon_last;
    int          checks = 0;
    int          errors = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? 20 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic model_word(input int i, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            exp_mem[i][exp_wr[i] % QN] = w[31-8*b -: 8];
            exp_wr[i]++;
        end
    endtask

    task automatic put(input int i, input logic [31:0] w, input bit accept);
        en_d[i]  = 1'b1;
        reg_d[i] = w;
        if (accept) model_word(i, w);
        tick();
        en_d[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget, input bit rand_ready);
        int n = 0;
        settle();
        while (busy_s[i] && n < budget) begin
            if (rand_ready) rdy_d[i] = ($urandom_range(0, 3) != 0);
            tick();
            settle();
            n++;
        end
        rdy_d[i] = 1'b1;
        check($sformatf("drain_busy[%0d]", i), 32'(busy_s[i]), 32'd0);
        check($sformatf("bytes_left[%0d]", i), 32'(exp_wr[i] - exp_rd[i]), 32'd0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_d[i]) begin
                exp_rd[i]     = exp_wr[i];
                gap_armed[i]  = 1'b0;
                prev_stall[i] = 1'b0;
                low_run[i]    = 0;
            end else begin
                if (prev_stall[i]) begin
                    check($sformatf("hold_valid[%0d]", i), 32'(valid_s[i]), 32'd1);
                    check($sformatf("hold_data[%0d]", i), 32'(data_s[i]), 32'(prev_data[i]));
                end
                if (valid_s[i]) begin
                    if (gap_armed[i]) begin
                        check($sformatf("frame_gap[%0d]", i), 32'(low_run[i]), 32'(gap_of(i) + 2));
                        gap_armed[i] = 1'b0;
                    end
                    low_run[i] = 0;
                end else begin
                    low_run[i]++;
                end
                mon_hs   = valid_s[i] && rdy_d[i];
                mon_last = 1'b0;
                if (mon_hs) begin
                    if (exp_rd[i] == exp_wr[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte[%0d]: got 0x%0h, want no byte", i, data_s[i]);
                    end else begin
                        mon_last = ((exp_wr[i] - exp_rd[i]) % 4) == 1;
                        check($sformatf("byte[%0d]", i), 32'(data_s[i]), 32'(exp_mem[i][exp_rd[i] % QN]));
                        exp_rd[i]++;
                        if (mon_last && exp_rd[i] != exp_wr[i]) gap_armed[i] = 1'b1;
                    end
                end
                check($sformatf("frame_done[%0d]", i), 32'(done_s[i]), 32'(mon_last));
                prev_stall[i] = valid_s[i] && !rdy_d[i];
                prev_data[i]  = data_s[i];
            end
        end
    end

    initial begin
        vec_t vecs [8];
        logic pat  [7];
        int   n;
        int   hs_seen;
        bit   found;
        bit   saw_valid;

        vecs[0] = '{en:1'b1, word:32'h0000_0001, level:3'd0, full:1'b0, ovf:1'b0, valid:1'b0};
        vecs[1] = '{en:1'b1, word:32'h0000_0002, level:3'd1, full:1'b0, ovf:1'b0, valid:1'b0};
        vecs[2] = '{en:1'b1, word:32'h0000_0003, level:3'd1, full:1'b0, ovf:1'b0, valid:1'b0};
        vecs[3] = '{en:1'b1, word:32'h0000_0004, level:3'd2, full:1'b0, ovf:1'b0, valid:1'b1};
        vecs[4] = '{en:1'b1, word:32'h0000_0005, level:3'd3, full:1'b0, ovf:1'b0, valid:1'b1};
        vecs[5] = '{en:1'b1, word:32'h0000_0006, level:3'd4, full:1'b1, ovf:1'b1, valid:1'b1};
        vecs[6] = '{en:1'b0, word:32'h0000_0000, level:3'd4, full:1'b1, ovf:1'b0, valid:1'b1};
        vecs[7] = '{en:1'b1, word:32'h0000_0007, level:3'd4, full:1'b1, ovf:1'b1, valid:1'b1};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 2; i++) begin
            rst_d[i]      = 1'b1;
            en_d[i]       = 1'b0;
            reg_d[i]      = '0;
            rdy_d[i]      = 1'b1;
            exp_wr[i]     = 0;
            exp_rd[i]     = 0;
            low_run[i]    = 0;
            gap_armed[i]  = 1'b0;
            prev_stall[i] = 1'b0;
            prev_data[i]  = '0;
        end
        tick();
        tick();
        rst_d[0] = 1'b0;
        rst_d[1] = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_valid[%0d]", i), 32'(valid_s[i]), 32'd0);
            check($sformatf("rst_level[%0d]", i), 32'(lvl_s[i]), 32'd0);
            check($sformatf("rst_full[%0d]", i), 32'(full_s[i]), 32'd0);
            check($sformatf("rst_busy[%0d]", i), 32'(busy_s[i]), 32'd0);
            check($sformatf("rst_ovf[%0d]", i), 32'(ovf_s[i]), 32'd0);
            check($sformatf("rst_data[%0d]", i), 32'(data_s[i]), 32'd0);
        end

        // Single word, ready held high: latency, byte order, gap length, busy release.
        put(0, 32'hA1B2_C3D4, 1'b1);
        settle();
        check("lat_idle_valid", 32'(valid_s[0]), 32'd0);
        tick();
        settle();
        check("lat_load_valid", 32'(valid_s[0]), 32'd0);
        tick();
        settle();
        check("lat_send_valid", 32'(valid_s[0]), 32'd1);
        check("lat_first_byte", 32'(data_s[0]), 32'hA1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (done_s[0]) found = 1'b1;
            else begin tick(); settle(); end
        end
        check("single_done_seen", 32'(found), 32'd1);
        saw_valid = 1'b0;
        for (int g = 0; g < 20; g++) begin
            tick();
            settle();
            saw_valid |= valid_s[0];
        end
        check("gap_valid_low", 32'(saw_valid), 32'd0);
        check("gap_busy", 32'(busy_s[0]), 32'd1);
        tick();
        settle();
        check("after_gap_busy", 32'(busy_s[0]), 32'd0);

        // Backpressure pattern while the frame is on the wire.
        rdy_d[0] = 1'b0;
        put(0, 32'hA1B2_C3D4, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (valid_s[0]) found = 1'b1;
            else tick();
        end
        check("bp_valid_seen", 32'(found), 32'd1);
        hs_seen = 0;
        for (int p = 0; p < 7; p++) begin
            rdy_d[0] = pat[p];
            settle();
            if (valid_s[0] && rdy_d[0]) hs_seen++;
            tick();
        end
        check("bp_handshakes", 32'(hs_seen), 32'd4);
        wait_idle(0, 100, 1'b0);

        // Fill with ready low; the FSM holds word 1 in the shift register.
        rdy_d[0] = 1'b0;
        for (int v = 0; v < 8; v++) begin
            en_d[0]  = vecs[v].en;
            reg_d[0] = vecs[v].word;
            if (vecs[v].en && !vecs[v].full) model_word(0, vecs[v].word);
            settle();
            check($sformatf("vec%0d_level", v), 32'(lvl_s[0]), 32'(vecs[v].level));
            check($sformatf("vec%0d_full", v), 32'(full_s[0]), 32'(vecs[v].full));
            check($sformatf("vec%0d_ovf", v), 32'(ovf_s[0]), 32'(vecs[v].ovf));
            check($sformatf("vec%0d_valid", v), 32'(valid_s[0]), 32'(vecs[v].valid));
            tick();
        end
        en_d[0] = 1'b0;

        // Release word 1, then write into the full FIFO on the cycle it pops.
        rdy_d[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (done_s[0]) found = 1'b1;
            else tick();
        end
        check("full_frame1_done", 32'(found), 32'd1);
        for (int g = 0; g < 21; g++) tick();
        en_d[0]  = 1'b1;
        reg_d[0] = 32'hDEAD_BEEF;
        settle();
        check("pop_push_ovf", 32'(ovf_s[0]), 32'd1);
        check("pop_push_full", 32'(full_s[0]), 32'd1);
        check("pop_push_level_pre", 32'(lvl_s[0]), 32'd4);
        tick();
        en_d[0] = 1'b0;
        settle();
        check("pop_push_level_post", 32'(lvl_s[0]), 32'd3);
        check("pop_push_ovf_clear", 32'(ovf_s[0]), 32'd0);
        wait_idle(0, 600, 1'b0);

        // Zero-gap instance: two words back to back.
        put(1, 32'h1122_3344, 1'b1);
        put(1, 32'h5566_7788, 1'b1);
        wait_idle(1, 100, 1'b0);

        // Reset after the second byte handshake with two words queued.
        put(0, 32'hCAFE_0123, 1'b1);
        put(0, 32'h4567_89AB, 1'b1);
        hs_seen = 0;
        for (int k = 0; k < 20 && hs_seen < 2; k++) begin
            settle();
            if (valid_s[0] && rdy_d[0]) hs_seen++;
            if (hs_seen < 2) tick();
        end
        check("rst_mid_hs", 32'(hs_seen), 32'd2);
        tick();
        rst_d[0] = 1'b1;
        tick();
        rst_d[0] = 1'b0;
        settle();
        check("rst_mid_valid", 32'(valid_s[0]), 32'd0);
        check("rst_mid_level", 32'(lvl_s[0]), 32'd0);
        check("rst_mid_busy", 32'(busy_s[0]), 32'd0);
        saw_valid = 1'b0;
        for (int g = 0; g < 30; g++) begin
            tick();
            settle();
            saw_valid |= valid_s[0];
        end
        check("rst_mid_quiet", 32'(saw_valid), 32'd0);

        // Random bursts with random backpressure on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 5; r++) begin
                n = $urandom_range(1, 4);
                for (int w = 0; w < n; w++) begin
                    rdy_d[i] = ($urandom_range(0, 3) != 0);
                    put(i, $urandom, 1'b1);
                end
                wait_idle(i, 400, 1'b1);
            end
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
